inst_prefetch_queue: RTL and testbench
======================================

// Module: inst_prefetch_queue
// PURPOSE
// - Instruction prefetch stage between the combinational instruction memory and the core's decode stage.
// - Drives the fetch PC and captures {pc, inst} pairs into a small FIFO.
// - Presents the FIFO head to decode with a valid/ready handshake.
// - Flushes the FIFO and restarts fetch on a redirect (taken branch/jump) from the core.
// PARAMETERS
// - DEPTH     4             FIFO entries; power of 2, >= 2
// - RESET_PC  32'h0000_0000 first fetch address after reset
// - NOP_INST  32'h0000_0013 value driven on deq_inst when the queue is empty (addi x0,x0,0)
// PORTS
// - clk             in   1   single clock, rising edge
// - reset           in   1   asynchronous, active-high
// - imem_addr       out  32  fetch PC to instruction memory; always word aligned
// - imem_rdata      in   32  instruction at imem_addr, valid combinationally in the same cycle
// - redirect_valid  in   1   core requests a fetch restart
// - redirect_pc     in   32  restart target; bits [1:0] ignored
// - deq_valid       out  1   head entry available
// - deq_ready       in   1   decode accepts the head this cycle
// - deq_pc          out  32  PC of the head entry
// - deq_inst        out  32  instruction of the head entry
// - count           out  $clog2(DEPTH+1)  current occupancy
// BEHAVIOUR
// - Reset (async assert, all state): fetch_pc=RESET_PC, rd_ptr=wr_ptr=0, count=0
//   - Resulting outputs: imem_addr=RESET_PC, deq_valid=0, deq_pc=0, deq_inst=NOP_INST.
//   - Storage array contents are don't-care.
//   - Reset mid-operation discards all queued entries.
// - Definitions:
//   - pop  = deq_valid & deq_ready
//   - push = !redirect_valid & (count<DEPTH | pop)
//   - Pushing into a full queue is allowed only when a pop happens in the same cycle.
// - Push: mem[wr_ptr] <= {fetch_pc, imem_rdata}; wr_ptr++; fetch_pc <= fetch_pc+4 (mod 2^32 wrap).
// - No push: fetch_pc holds; imem_addr is unchanged (imem re-read is harmless).
// - Pop: rd_ptr++.
// - Count update: count <= count + push - pop.
//   - Simultaneous push and pop leaves count unchanged.
// - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
//   - Full vs empty is decided by count only, never by pointer equality.
// - deq_valid = (count != 0), registered-state derived; no combinational path from deq_ready or imem_rdata.
// - deq_pc/deq_inst = mem[rd_ptr] when deq_valid; otherwise 0 / NOP_INST.
// - Redirect (highest priority):
//   - Next state: rd_ptr=wr_ptr=count=0, fetch_pc <= {redirect_pc[31:2],2'b00}.
//   - No push in the redirect cycle.
//   - A pop in the same cycle is treated as consumed (the core issues the redirect itself), then discarded.
//   - Cycle after redirect: imem_addr=target, deq_valid=0.
//   - Cycle after that: target entry at head, deq_valid=1.
// - Latency:
//   - Address A presented in cycle N appears at the head no earlier than N+1.
//   - Steady-state throughput is 1 instruction/cycle with deq_ready held high.
// - Back-to-back redirects: the last one wins; each restarts fetch at its own target.
// - deq_ready low with a full queue: fetch stalls; head and all entries hold their values.
// STRUCTURE
// - riscv_pkg holds:
//   - NOP constant `RV_NOP = 32'h0000_0013`
//   - typedef `fetch_entry_t` (struct packed {logic [31:0] pc; logic [31:0] inst;})
//   - PC increment constant 4
// - One sub-module, `fetch_fifo`:
//   - Parameterized DEPTH, stores fetch_entry_t.
//   - push/pop/flush inputs; head/count outputs.
//   - Async reset of pointers and count only.
// - Top level holds fetch_pc, redirect priority, push/pop decode and output muxing.
// TESTING
// - Reset, deq_ready=0, imem returns 32'hA0+addr:
//   - Cycles 1..4 fill entries for PC 0,4,8,C; count=4.
//   - imem_addr then holds at 0x10; deq_pc=0 throughout.
// - Steady stream, deq_ready=1 from reset:
//   - deq_pc sequence 0,4,8,... one per cycle from cycle 1; count stays 1.
// - Full queue (count=4), single pop with deq_ready=1:
//   - Entry 0x10 is pushed the same cycle; count stays 4; head becomes 0x4.
// - Redirect to 0x0000_0103 while count=3:
//   - Next cycle: count=0, deq_valid=0, imem_addr=0x100.
//   - Following cycle: deq_pc=0x100.
// - Wrap-around:
//   - Redirect to 0xFFFF_FFF8, deq_ready=1: deq_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
//   - Pointers cycle past DEPTH-1 with no lost entries.
// - Async reset asserted mid-stream between clock edges:
//   - deq_valid=0, imem_addr=RESET_PC immediately, before the next clock edge.
//   - After release: fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch-side definitions.
// - RV_NOP        : canonical NOP (addi x0,x0,0)
// - PC_INCR       : sequential fetch stride in bytes
// - fetch_entry_t : {pc, inst} pair held in the prefetch FIFO
package riscv_pkg;

    localparam logic [31:0] RV_NOP  = 32'h0000_0013;
    localparam logic [31:0] PC_INCR = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of fetch_entry_t with flush.
// Ports:
//   clk, reset : clock and asynchronous active-high reset (pointers/count only)
//   push, pop  : write wdata at tail / advance head; both may occur in one cycle
//   flush      : empties the queue next cycle; overrides push and pop
//   wdata      : entry to write on push
//   head       : entry at the read pointer (meaningless when count == 0)
//   count      : current occupancy
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               wdata,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by plain overflow.
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch stage between a combinational instruction memory and decode.
// Ports:
//   clk, reset      : clock and asynchronous active-high reset
//   imem_addr       : word-aligned fetch PC driven to instruction memory
//   imem_rdata      : instruction at imem_addr, same cycle
//   redirect_valid  : restart fetch at redirect_pc (flushes queue, highest priority)
//   redirect_pc     : restart target, bits [1:0] ignored
//   deq_valid/ready : handshake for the queue head
//   deq_pc/deq_inst : head entry, or 0 / NOP_INST when empty
//   count           : current occupancy
module inst_prefetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = RV_NOP
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [31:0]                deq_pc,
    output logic [31:0]                deq_inst,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         push, pop;
    fetch_entry_t wr_entry, head;
    logic         unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // deq_valid depends only on registered count, never on deq_ready.
    assign deq_valid = (count != '0);
    assign pop       = deq_valid & deq_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push      = !redirect_valid & ((count < CNT_W'(DEPTH)) | pop);

    assign wr_entry.pc   = fetch_pc_q;
    assign wr_entry.inst = imem_rdata;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + PC_INCR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wr_entry),
        .head  (head),
        .count (count)
    );

    assign imem_addr = fetch_pc_q;
    assign deq_pc    = deq_valid ? head.pc   : 32'h0;
    assign deq_inst  = deq_valid ? head.inst : NOP_INST;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue against a queue-based reference model.
module tb_inst_prefetch_queue;
    import riscv_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   imem_addr, imem_rdata, redirect_pc, deq_pc, deq_inst;
    logic          redirect_valid, deq_valid, deq_ready;
    logic [CW-1:0] count;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of {pc, inst} plus next fetch address.
    logic [63:0] mq[$];
    logic [31:0] m_fpc;

    always #5 clk = ~clk;

    assign imem_rdata = 32'hA0 + imem_addr;

    inst_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_pc         (deq_pc),
        .deq_inst       (deq_inst),
        .count          (count)
    );

    function automatic logic [31:0] exp_pc();
        return (mq.size() != 0) ? mq[0][63:32] : 32'h0;
    endfunction

    function automatic logic [31:0] exp_inst();
        return (mq.size() != 0) ? mq[0][31:0] : 32'h0000_0013;
    endfunction

    // Apply one clock with the currently driven inputs; model follows the rules directly.
    task automatic advance();
        bit pop, push;
        pop  = (mq.size() != 0) && deq_ready;
        push = !redirect_valid && ((mq.size() < DEPTH) || pop);
        if (redirect_valid) begin
            mq.delete();
            m_fpc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({m_fpc, m_fpc + 32'hA0});
                m_fpc = m_fpc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        deq_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mq.delete();
        m_fpc = 32'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        deq_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #3;
        checks += 4;
        if (deq_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", deq_valid);
        end
        if (imem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr);
        end
        if (deq_pc !== 32'h0 || deq_inst !== 32'h13) begin
            errors++; $display("FAIL reset_head: got %h/%h expected 0/13", deq_pc, deq_inst);
        end
        if (count !== '0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", count);
        end
        do_reset();
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            advance();
            checks += 3;
            if (count !== CW'((i < 4) ? i : 4)) begin
                errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count,
                                   (i < 4) ? i : 4);
            end
            if (imem_addr !== 32'((i < 4) ? 4 * i : 16)) begin
                errors++; $display("FAIL fill_addr[%0d]: got %h expected %h", i, imem_addr,
                                   (i < 4) ? 4 * i : 16);
            end
            if (deq_pc !== 32'h0 || deq_inst !== 32'hA0) begin
                errors++; $display("FAIL fill_head[%0d]: got %h/%h expected 0/a0", i, deq_pc,
                                   deq_inst);
            end
        end
    endtask

    // Continues from a full queue left by test_fill.
    task automatic test_full_pop();
        deq_ready = 1'b1;
        advance();
        deq_ready = 1'b0;
        checks += 3;
        if (count !== CW'(4)) begin
            errors++; $display("FAIL fullpop_count: got %0d expected 4", count);
        end
        if (deq_pc !== 32'h4) begin
            errors++; $display("FAIL fullpop_head: got %h expected 4", deq_pc);
        end
        if (imem_addr !== 32'h14) begin
            errors++; $display("FAIL fullpop_addr: got %h expected 14", imem_addr);
        end
        // Stalled full queue holds its head.
        advance();
        advance();
        checks++;
        if (deq_pc !== 32'h4 || count !== CW'(4) || imem_addr !== 32'h14) begin
            errors++; $display("FAIL stall_hold: got pc=%h cnt=%0d addr=%h expected 4/4/14",
                               deq_pc, count, imem_addr);
        end
    endtask

    task automatic test_stream();
        do_reset();
        deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            advance();
            checks += 2;
            if (deq_pc !== 32'(4 * i) || deq_valid !== 1'b1) begin
                errors++; $display("FAIL stream_pc[%0d]: got %h v=%b expected %h v=1", i, deq_pc,
                                   deq_valid, 4 * i);
            end
            if (count !== CW'(1)) begin
                errors++; $display("FAIL stream_count[%0d]: got %0d expected 1", i, count);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        advance();
        advance();
        advance();
        checks++;
        if (count !== CW'(3)) begin
            errors++; $display("FAIL redir_pre_count: got %0d expected 3", count);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        advance();
        redirect_valid = 1'b0;
        checks += 2;
        if (count !== '0 || deq_valid !== 1'b0) begin
            errors++; $display("FAIL redir_flush: got cnt=%0d v=%b expected 0/0", count, deq_valid);
        end
        if (imem_addr !== 32'h100) begin
            errors++; $display("FAIL redir_addr: got %h expected 100", imem_addr);
        end
        advance();
        checks++;
        if (deq_valid !== 1'b1 || deq_pc !== 32'h100 || deq_inst !== 32'h1A0) begin
            errors++; $display("FAIL redir_head: got v=%b %h/%h expected 1 100/1a0", deq_valid,
                               deq_pc, deq_inst);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'hFFFF_FFF8;
        exp_seq[1] = 32'hFFFF_FFFC;
        exp_seq[2] = 32'h0000_0000;
        deq_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        advance();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            advance();
            checks++;
            if (deq_pc !== exp_seq[i]) begin
                errors++; $display("FAIL wrap_pc[%0d]: got %h expected %h", i, deq_pc, exp_seq[i]);
            end
        end
        // Run the pointers around several times with intermittent stalls.
        for (int i = 0; i < 12; i++) begin
            deq_ready = (i % 3) != 0;
            advance();
            checks++;
            if (deq_pc !== exp_pc() || count !== CW'(mq.size())) begin
                errors++; $display("FAIL wrap_ptr[%0d]: got %h/%0d expected %h/%0d", i, deq_pc,
                                   count, exp_pc(), mq.size());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            deq_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom();
            advance();
            checks++;
            if (deq_valid !== (mq.size() != 0) || count !== CW'(mq.size()) ||
                imem_addr !== m_fpc || deq_pc !== exp_pc() || deq_inst !== exp_inst()) begin
                errors++;
                $display("FAIL random[%0d]: got v=%b c=%0d a=%h pc=%h i=%h expected v=%b c=%0d a=%h pc=%h i=%h",
                         i, deq_valid, count, imem_addr, deq_pc, deq_inst, mq.size() != 0,
                         mq.size(), m_fpc, exp_pc(), exp_inst());
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        deq_ready = 1'b0;
        advance();
        advance();
        advance();
        @(negedge clk);
        reset = 1'b1;
        mq.delete();
        m_fpc = 32'h0;
        #1;
        checks += 2;
        if (deq_valid !== 1'b0 || count !== '0) begin
            errors++; $display("FAIL async_valid: got v=%b c=%0d expected 0/0", deq_valid, count);
        end
        if (imem_addr !== 32'h0) begin
            errors++; $display("FAIL async_addr: got %h expected 0", imem_addr);
        end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        deq_ready = 1'b1;
        advance();
        checks++;
        if (deq_pc !== 32'h0 || imem_addr !== 32'h4 || count !== CW'(1)) begin
            errors++; $display("FAIL async_restart: got pc=%h a=%h c=%0d expected 0/4/1", deq_pc,
                               imem_addr, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_pop();
        test_stream();
        test_redirect();
        test_wrap();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
